// File: rtl/rs232_pkg.sv
// Shared definitions for the buffered RS-232 transmitter: FSM encoding,
// baud select codes and the bit-period divisor calculation.
package rs232_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } tx_state_t;

  localparam logic [1:0] BAUD_115200 = 2'd0;
  localparam logic [1:0] BAUD_57600  = 2'd1;
  localparam logic [1:0] BAUD_38400  = 2'd2;
  localparam logic [1:0] BAUD_19200  = 2'd3;

  // Clock cycles per bit period (integer division, truncating).
  function automatic int unsigned baud_div(input int unsigned clk_freq,
                                           input int unsigned baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/rs232_fifo.sv
// Synchronous transmit FIFO with registered occupancy count.
// dout always presents the head entry (show-ahead).
module rs232_fifo
  import rs232_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_push;
  logic             w_pop;

  assign full   = (r_count == FULL_CNT);
  assign empty  = (r_count == '0);
  assign count  = r_count;
  assign dout   = r_mem[r_rd_ptr];
  assign w_push = push && !full;
  assign w_pop  = pop && !empty;

  // Storage array: written on accepted push, never reset.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= din;
    end
  end

  // Pointers wrap naturally modulo DEPTH; count tracks push minus pop.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/rs232_tx_buf.sv
// Buffered RS-232 transmitter: FIFO front end, per-frame latched line
// configuration, registered txd output, back-to-back frames without gaps.
module rs232_tx_buf
  import rs232_pkg::*;
#(
  parameter int unsigned CLOCK_FREQ = 50000000,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          wr,
  input  logic [7:0]                    data_in,
  input  logic [1:0]                    baud_sel,
  input  logic                          dbits,
  input  logic                          par_en,
  input  logic                          par_odd,
  input  logic                          stop2,
  output logic                          rdy,
  output logic                          empty,
  output logic [$clog2(FIFO_DEPTH):0]   count,
  output logic                          ovf,
  output logic                          txd
);

  localparam logic [15:0] DIV_115200 = 16'(baud_div(CLOCK_FREQ, 115200));
  localparam logic [15:0] DIV_57600  = 16'(baud_div(CLOCK_FREQ, 57600));
  localparam logic [15:0] DIV_38400  = 16'(baud_div(CLOCK_FREQ, 38400));
  localparam logic [15:0] DIV_19200  = 16'(baud_div(CLOCK_FREQ, 19200));

  tx_state_t   r_state;
  tx_state_t   w_state_n;
  logic [15:0] r_tick;
  logic [15:0] w_tick_n;
  logic [15:0] r_div;
  logic [15:0] w_div_sel;
  logic [2:0]  r_bit;
  logic [2:0]  w_bit_n;
  logic [7:0]  r_shift;
  logic [7:0]  w_shift_n;
  logic        r_par;
  logic        w_par_n;
  logic        r_txd;
  logic        w_txd_n;
  logic        r_dbits;
  logic        r_par_en;
  logic        r_par_odd;
  logic        r_stop2;
  logic        r_ovf;
  logic        w_load;
  logic        w_push;
  logic        w_fifo_full;
  logic        w_fifo_empty;
  logic [7:0]  w_fifo_dout;
  logic        w_last_tick;
  logic        w_last_bit;

  assign rdy         = !w_fifo_full;
  assign w_push      = wr && !w_fifo_full;
  assign empty       = w_fifo_empty && (r_state == ST_IDLE);
  assign ovf         = r_ovf;
  assign txd         = r_txd;
  assign w_last_tick = (r_tick == r_div - 16'd1);
  assign w_last_bit  = (r_bit == (r_dbits ? 3'd6 : 3'd7));

  rs232_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (w_push),
    .pop   (w_load),
    .din   (data_in),
    .dout  (w_fifo_dout),
    .full  (w_fifo_full),
    .empty (w_fifo_empty),
    .count (count)
  );

  // Bit-period divisor for the currently requested baud rate.
  always_comb begin
    w_div_sel = DIV_115200;
    case (baud_sel)
      BAUD_115200: w_div_sel = DIV_115200;
      BAUD_57600:  w_div_sel = DIV_57600;
      BAUD_38400:  w_div_sel = DIV_38400;
      BAUD_19200:  w_div_sel = DIV_19200;
      default:     w_div_sel = DIV_115200;
    endcase
  end

  // Next-state, datapath and next-txd logic; txd is computed one edge
  // ahead so the registered output changes exactly at bit boundaries.
  always_comb begin
    w_state_n = r_state;
    w_tick_n  = w_last_tick ? '0 : r_tick + 16'd1;
    w_bit_n   = r_bit;
    w_shift_n = r_shift;
    w_par_n   = r_par;
    w_txd_n   = r_txd;
    w_load    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_tick_n = '0;
        w_txd_n  = 1'b1;
        if (!w_fifo_empty) begin
          w_load = 1'b1;
        end
      end
      ST_START: begin
        if (w_last_tick) begin
          w_state_n = ST_DATA;
          w_txd_n   = r_shift[0];
        end
      end
      ST_DATA: begin
        if (w_last_tick) begin
          w_par_n   = r_par ^ r_shift[0];
          w_shift_n = {1'b0, r_shift[7:1]};
          if (w_last_bit) begin
            w_bit_n = '0;
            if (r_par_en) begin
              w_state_n = ST_PARITY;
              w_txd_n   = r_par ^ r_shift[0] ^ r_par_odd;
            end else begin
              w_state_n = ST_STOP;
              w_txd_n   = 1'b1;
            end
          end else begin
            w_bit_n = r_bit + 3'd1;
            w_txd_n = r_shift[1];
          end
        end
      end
      ST_PARITY: begin
        if (w_last_tick) begin
          w_state_n = ST_STOP;
          w_txd_n   = 1'b1;
        end
      end
      ST_STOP: begin
        if (w_last_tick) begin
          if (r_stop2 && (r_bit == 3'd0)) begin
            w_bit_n = 3'd1;
          end else if (!w_fifo_empty) begin
            w_load = 1'b1;
          end else begin
            w_state_n = ST_IDLE;
            w_bit_n   = '0;
            w_txd_n   = 1'b1;
          end
        end
      end
      default: begin
        w_state_n = ST_IDLE;
        w_tick_n  = '0;
        w_bit_n   = '0;
        w_txd_n   = 1'b1;
      end
    endcase
    // A pop (from IDLE or the last stop cycle) always starts a fresh frame.
    if (w_load) begin
      w_state_n = ST_START;
      w_tick_n  = '0;
      w_bit_n   = '0;
      w_shift_n = w_fifo_dout;
      w_par_n   = 1'b0;
      w_txd_n   = 1'b0;
    end
  end

  // State, counters, shift register and txd registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_tick  <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_par   <= 1'b0;
      r_txd   <= 1'b1;
    end else begin
      r_state <= w_state_n;
      r_tick  <= w_tick_n;
      r_bit   <= w_bit_n;
      r_shift <= w_shift_n;
      r_par   <= w_par_n;
      r_txd   <= w_txd_n;
    end
  end

  // Line configuration is captured only when a byte is popped.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_div     <= DIV_115200;
      r_dbits   <= 1'b0;
      r_par_en  <= 1'b0;
      r_par_odd <= 1'b0;
      r_stop2   <= 1'b0;
    end else if (w_load) begin
      r_div     <= w_div_sel;
      r_dbits   <= dbits;
      r_par_en  <= par_en;
      r_par_odd <= par_odd;
      r_stop2   <= stop2;
    end
  end

  // Sticky overflow flag: a write while the FIFO is full.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ovf <= 1'b0;
    end else if (wr && w_fifo_full) begin
      r_ovf <= 1'b1;
    end
  end

endmodule

// File: tb/tb_rs232_tx_buf.sv
// Directed bench for rs232_tx_buf with a scoreboard of expected frames.
module tb_rs232_tx_buf;

  localparam int CLK_HZ = 50000000;

  typedef struct packed {
    logic [7:0]  data;
    logic        d7;
    logic        pe;
    logic        po;
    logic        s2;
    logic [15:0] div;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       wr;
  logic [7:0] data_in;
  logic [1:0] baud_sel;
  logic       dbits;
  logic       par_en;
  logic       par_odd;
  logic       stop2;
  logic       rdy;
  logic       empty;
  logic [3:0] count;
  logic       ovf;
  logic       txd;

  exp_t sbq[$];
  int   n_cmp = 0;
  int   n_err = 0;
  logic [7:0] burst [9] = '{8'h01, 8'h23, 8'h45, 8'h67, 8'h89, 8'hAB, 8'hCD, 8'hEF, 8'h3C};

  always #5 clk = ~clk;

  rs232_tx_buf #(
    .CLOCK_FREQ (50000000),
    .FIFO_DEPTH (8)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .wr       (wr),
    .data_in  (data_in),
    .baud_sel (baud_sel),
    .dbits    (dbits),
    .par_en   (par_en),
    .par_odd  (par_odd),
    .stop2    (stop2),
    .rdy      (rdy),
    .empty    (empty),
    .count    (count),
    .ovf      (ovf),
    .txd      (txd)
  );

  function automatic int div_of(input logic [1:0] s);
    case (s)
      2'd0:    return CLK_HZ / 115200;
      2'd1:    return CLK_HZ / 57600;
      2'd2:    return CLK_HZ / 38400;
      default: return CLK_HZ / 19200;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, expv);
    end
  endtask

  // One-cycle write starting at a negedge; returns at the following negedge.
  task automatic do_wr(input logic [7:0] d, input bit acc, input string tag);
    chk({tag, "_rdy"}, 32'(rdy), 32'(acc));
    wr      = 1'b1;
    data_in = d;
    if (acc) begin
      sbq.push_back('{data: d, d7: dbits, pe: par_en, po: par_odd, s2: stop2,
                      div: 16'(div_of(baud_sel))});
    end
    @(negedge clk);
    wr = 1'b0;
  endtask

  // Check one frame cycle by cycle against the scoreboard head.
  // max_bits > 0 limits the check to the first max_bits bit periods.
  task automatic check_frame(input bit b2b, input int max_bits, input string tag);
    exp_t       e;
    logic       bits[$];
    logic [7:0] rx;
    logic [7:0] mask;
    int         bad;
    int         nd;
    int         nb;
    bit         got;
    bad = 0;
    rx  = '0;
    got = 1'b0;
    if (b2b) begin
      @(negedge clk);
      chk({tag, "_no_gap_start"}, 32'(txd), 32'd0);
    end else begin
      for (int t = 0; t < 6000; t++) begin
        @(negedge clk);
        if (txd === 1'b0) begin
          got = 1'b1;
          break;
        end
      end
      chk({tag, "_start_seen"}, 32'(got), 32'd1);
      if (!got) return;
    end
    chk({tag, "_sb_pending"}, 32'(sbq.size() != 0), 32'd1);
    if (sbq.size() == 0) return;
    e    = sbq.pop_front();
    nd   = e.d7 ? 7 : 8;
    mask = e.d7 ? 8'h7F : 8'hFF;
    bits.push_back(1'b0);
    for (int i = 0; i < nd; i++) bits.push_back(e.data[i]);
    if (e.pe) bits.push_back((^(e.data & mask)) ^ e.po);
    bits.push_back(1'b1);
    if (e.s2) bits.push_back(1'b1);
    nb = (max_bits > 0 && max_bits < bits.size()) ? max_bits : bits.size();
    for (int b = 0; b < nb; b++) begin
      for (int c = 0; c < int'(e.div); c++) begin
        if (!(b == 0 && c == 0)) @(negedge clk);
        if (txd !== bits[b]) bad++;
        if (b >= 1 && b <= nd && c == int'(e.div) / 2) rx[b-1] = txd;
      end
    end
    chk({tag, "_bad_samples"}, 32'(bad), 32'd0);
    if (max_bits == 0) chk({tag, "_data"}, 32'(rx), 32'(e.data & mask));
  endtask

  initial begin
    #20ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int bad;
    rst = 1'b1; wr = 1'b0; data_in = '0; baud_sel = 2'd0;
    dbits = 1'b0; par_en = 1'b0; par_odd = 1'b0; stop2 = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_txd", 32'(txd), 32'd1);
    chk("reset_count", 32'(count), 32'd0);
    chk("reset_rdy", 32'(rdy), 32'd1);
    chk("reset_empty", 32'(empty), 32'd1);
    chk("reset_ovf", 32'(ovf), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // 8N1 at 115200, latency to start bit
    fork
      check_frame(1'b0, 0, "t039");
      begin
        do_wr(8'h55, 1'b1, "t039");
        chk("t039_n1_txd", 32'(txd), 32'd1);
        chk("t039_n1_count", 32'(count), 32'd1);
        @(negedge clk);
        chk("t039_n2_txd", 32'(txd), 32'd0);
        chk("t039_n2_count", 32'(count), 32'd0);
        chk("t039_n2_empty", 32'(empty), 32'd0);
      end
    join
    @(negedge clk);
    chk("t039_idle_empty", 32'(empty), 32'd1);

    // 7E2 at 19200
    baud_sel = 2'd3; dbits = 1'b1; par_en = 1'b1; par_odd = 1'b0; stop2 = 1'b1;
    fork
      check_frame(1'b0, 0, "t040");
      do_wr(8'h41, 1'b1, "t040");
    join

    // burst of 9 writes, then a write into the full FIFO
    baud_sel = 2'd0; dbits = 1'b0; par_en = 1'b0; par_odd = 1'b0; stop2 = 1'b0;
    fork
      begin
        check_frame(1'b0, 0, "t041_f0");
        for (int k = 1; k < 9; k++) check_frame(1'b1, 0, $sformatf("t041_f%0d", k));
      end
      begin
        for (int k = 0; k < 9; k++) do_wr(burst[k], 1'b1, "t041_wr");
        chk("t041_full_count", 32'(count), 32'd8);
        do_wr(8'hEE, 1'b0, "t042_full");
        chk("t042_ovf", 32'(ovf), 32'd1);
        chk("t042_count", 32'(count), 32'd8);
      end
    join
    @(negedge clk);
    chk("t042_ovf_sticky", 32'(ovf), 32'd1);

    // reset in the middle of the data bits
    do_wr(8'h00, 1'b1, "t043");
    do_wr(8'h33, 1'b1, "t043");
    repeat (500) @(negedge clk);
    chk("t043_mid_data_txd", 32'(txd), 32'd0);
    chk("t043_queued", 32'(count), 32'd1);
    rst = 1'b1; wr = 1'b1; data_in = 8'h77;
    @(negedge clk);
    rst = 1'b0; wr = 1'b0;
    chk("t043_rst_txd", 32'(txd), 32'd1);
    chk("t043_rst_count", 32'(count), 32'd0);
    chk("t043_rst_empty", 32'(empty), 32'd1);
    chk("t043_rst_rdy", 32'(rdy), 32'd1);
    chk("t043_rst_ovf", 32'(ovf), 32'd0);
    sbq.delete();
    bad = 0;
    repeat (500) begin
      @(negedge clk);
      if (txd !== 1'b1 || count != 4'd0) bad++;
    end
    chk("t043_quiet_after_rst", 32'(bad), 32'd0);
    fork
      check_frame(1'b0, 0, "t043_a5");
      do_wr(8'hA5, 1'b1, "t043_a5");
    join

    // baud change mid-frame applies to the next frame only
    fork
      begin
        check_frame(1'b0, 0, "t044_f0");
        check_frame(1'b1, 2, "t044_f1");
      end
      begin
        do_wr(8'hC3, 1'b1, "t044");
        repeat (1000) @(negedge clk);
        baud_sel = 2'd3;
        do_wr(8'h5B, 1'b1, "t044");
      end
    join
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("t044_rst_txd", 32'(txd), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
